// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// Used by both uart_rx and uart_tx so the two ends agree on bit timing.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain (two flops)
// and adds a third flop so a falling edge can be flagged for one cycle.
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rx_data,
    output logic rx_s,
    output logic rx_fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = rx_data;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Reset to the idle-high level so releasing reset never looks like an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rx_s    = s2_q;
    assign rx_fall = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-byte valid/ready
// holding register, with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_data,
    input  logic       rx_ready,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .rx_data (rx_data),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [7:0]                 dout_q, dout_d;
    logic                       valid_q, valid_d;
    logic                       ferr_q, ferr_d;
    logic                       ovr_q, ovr_d;
    logic                       good_stop;
    logic                       bad_stop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end
            // Half a bit into the start bit: a line that is already high was a glitch
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    good_stop = rx_s;
                    bad_stop  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Holding register: a consumer accept and a new load may coincide, the load wins
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = bad_stop;
        ovr_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (good_stop) begin
            if (valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout      = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
